// File: rtl/multicycle_control.sv
// Main control FSM for the 16-bit multi-cycle core: sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             mode,
    input  logic             zero,
    input  logic             negative,
    output logic [3:0]       alu_op,
    output logic             alu_src_b,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             imem_read,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             ext_sign,
    output logic             byte_load,
    output logic             rr_write,
    output logic             instr_done,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_LB   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BGT  = 4'h8;
    localparam logic [3:0] OP_BLT  = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_SV   = 4'hF;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   instr_count_q;
    logic [CNT_W-1:0]   instr_count_d;
    logic               br_taken;
    logic               is_load;
    logic               is_store;
    logic               uses_imm;

    assign is_load  = (opcode == OP_LW) || (opcode == OP_LB);
    assign is_store = (opcode == OP_SW) || (opcode == OP_SV);
    assign uses_imm = is_load || is_store ||
                      (opcode == OP_ADDI) || (opcode == OP_ANDI);

    // Sign comes from result bit 15 only; overflow is deliberately ignored.
    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            OP_BGT:  br_taken = !zero && !negative;
            OP_BLT:  br_taken = negative;
            OP_BEQ:  br_taken = zero;
            OP_BNE:  br_taken = !zero;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        alu_op     = 4'b0000;
        alu_src_b  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        imem_read  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        ext_sign   = 1'b0;
        byte_load  = 1'b0;
        rr_write   = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_read = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                pc_src    = 2'b00;
                state_d   = S_DECODE;
            end

            S_DECODE: begin
                case (opcode)
                    OP_JMP: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    OP_CALL: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        rr_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    OP_RET: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b11;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                alu_op    = opcode;
                alu_src_b = uses_imm;
                ext_sign  = (opcode != OP_ANDI);
                case (opcode)
                    OP_AND, OP_ADD, OP_SUB,
                    OP_ADDI, OP_ANDI: state_d = S_WB;
                    OP_LW, OP_LB,
                    OP_SW, OP_SV:     state_d = S_MEM;
                    OP_BGT, OP_BLT,
                    OP_BEQ, OP_BNE: begin
                        instr_done = 1'b1;
                        pc_write   = br_taken;
                        pc_src     = br_taken ? 2'b01 : 2'b00;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                if (is_load) begin
                    dmem_read = 1'b1;
                    if (opcode == OP_LB) begin
                        byte_load = 1'b1;
                        ext_sign  = mode;
                    end
                    state_d = S_WB;
                end else if (is_store) begin
                    dmem_write = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                mem_to_reg = is_load;
                if (opcode == OP_LB) begin
                    byte_load = 1'b1;
                    ext_sign  = mode;
                end
                state_d = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase

        // Reset overrides everything so an abandoned instruction writes nothing.
        if (reset) begin
            state_d    = S_FETCH;
            alu_op     = 4'b0000;
            alu_src_b  = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            ir_write   = 1'b0;
            imem_read  = 1'b0;
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            ext_sign   = 1'b0;
            byte_load  = 1'b0;
            rr_write   = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_comb begin
        if (reset) begin
            instr_count_d = '0;
        end else begin
            instr_count_d = instr_count_q + CNT_W'(instr_done);
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        instr_count_q <= instr_count_d;
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control
// vectors are queued when an instruction is issued and popped each cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h1;
    logic       mode = 1'b0;
    logic       zero = 1'b0;
    logic       negative = 1'b0;

    logic [3:0]  alu_op;
    logic        alu_src_b, pc_write, ir_write, imem_read;
    logic [1:0]  pc_src;
    logic        dmem_read, dmem_write, reg_write, mem_to_reg;
    logic        ext_sign, byte_load, rr_write, instr_done;
    logic [2:0]  state;
    logic [15:0] instr_count;

    logic [3:0]  w_alu_op;
    logic        w_alu_src_b, w_pc_write, w_ir_write, w_imem_read;
    logic [1:0]  w_pc_src;
    logic        w_dmem_read, w_dmem_write, w_reg_write, w_mem_to_reg;
    logic        w_ext_sign, w_byte_load, w_rr_write, w_instr_done;
    logic [2:0]  w_state;
    logic [2:0]  w_instr_count;

    multicycle_control #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mode(mode),
        .zero(zero), .negative(negative),
        .alu_op(alu_op), .alu_src_b(alu_src_b), .pc_write(pc_write),
        .pc_src(pc_src), .ir_write(ir_write), .imem_read(imem_read),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .ext_sign(ext_sign), .byte_load(byte_load), .rr_write(rr_write),
        .instr_done(instr_done), .state(state), .instr_count(instr_count)
    );

    // Narrow-counter copy so counter wrap is reachable in a few cycles.
    multicycle_control #(.CNT_W(3)) dut_w (
        .clk(clk), .reset(reset), .opcode(opcode), .mode(mode),
        .zero(zero), .negative(negative),
        .alu_op(w_alu_op), .alu_src_b(w_alu_src_b), .pc_write(w_pc_write),
        .pc_src(w_pc_src), .ir_write(w_ir_write), .imem_read(w_imem_read),
        .dmem_read(w_dmem_read), .dmem_write(w_dmem_write),
        .reg_write(w_reg_write), .mem_to_reg(w_mem_to_reg),
        .ext_sign(w_ext_sign), .byte_load(w_byte_load),
        .rr_write(w_rr_write), .instr_done(w_instr_done),
        .state(w_state), .instr_count(w_instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  aop;
        logic        asb;
        logic        pcw;
        logic [1:0]  pcs;
        logic        irw;
        logic        imr;
        logic        dmr;
        logic        dmw;
        logic        rgw;
        logic        m2r;
        logic        exs;
        logic        byl;
        logic        rrw;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_cnt = '0;
    string       cur = "";

    function automatic exp_t actual();
        exp_t a;
        a = '{st: state, aop: alu_op, asb: alu_src_b, pcw: pc_write,
              pcs: pc_src, irw: ir_write, imr: imem_read, dmr: dmem_read,
              dmw: dmem_write, rgw: reg_write, m2r: mem_to_reg,
              exs: ext_sign, byl: byte_load, rrw: rr_write,
              done: instr_done, cnt: instr_count};
        return a;
    endfunction

    function automatic exp_t actual_w();
        exp_t a;
        a = '{st: w_state, aop: w_alu_op, asb: w_alu_src_b,
              pcw: w_pc_write, pcs: w_pc_src, irw: w_ir_write,
              imr: w_imem_read, dmr: w_dmem_read, dmw: w_dmem_write,
              rgw: w_reg_write, m2r: w_mem_to_reg, exs: w_ext_sign,
              byl: w_byte_load, rrw: w_rr_write, done: w_instr_done,
              cnt: {13'b0, w_instr_count}};
        return a;
    endfunction

    task automatic push_v(input exp_t v);
        v.cnt = model_cnt;
        q.push_back(v);
        if (v.done) model_cnt = model_cnt + 16'd1;
    endtask

    // Reference sequence built per instruction class.
    task automatic push_instr(input logic [3:0] op, input logic md,
                              input logic z, input logic n);
        exp_t v;
        logic taken;
        v = '0;
        v.st = 3'd0; v.imr = 1'b1; v.irw = 1'b1; v.pcw = 1'b1;
        push_v(v);
        v = '0;
        v.st = 3'd1;
        if (op >= 4'hC && op <= 4'hE) begin
            v.pcw = 1'b1;
            v.pcs = (op == 4'hE) ? 2'b11 : 2'b10;
            v.rrw = (op == 4'hD);
            v.done = 1'b1;
            push_v(v);
            return;
        end
        push_v(v);
        v = '0;
        v.st = 3'd2;
        v.aop = op;
        v.asb = (op >= 4'h3 && op <= 4'h7) || (op == 4'hF);
        v.exs = (op != 4'h4);
        if (op >= 4'h8 && op <= 4'hB) begin
            case (op)
                4'h8:    taken = (z == 1'b0) && (n == 1'b0);
                4'h9:    taken = (n == 1'b1);
                4'hA:    taken = (z == 1'b1);
                default: taken = (z == 1'b0);
            endcase
            v.pcw = taken;
            v.pcs = taken ? 2'b01 : 2'b00;
            v.done = 1'b1;
            push_v(v);
            return;
        end
        push_v(v);
        if (op >= 4'h5 && op <= 4'h7 || op == 4'hF) begin
            v = '0;
            v.st = 3'd3;
            if (op == 4'h7 || op == 4'hF) begin
                v.dmw = 1'b1;
                v.done = 1'b1;
                push_v(v);
                return;
            end
            v.dmr = 1'b1;
            if (op == 4'h6) begin
                v.byl = 1'b1;
                v.exs = md;
            end
            push_v(v);
        end
        v = '0;
        v.st = 3'd4;
        v.rgw = 1'b1;
        v.done = 1'b1;
        v.m2r = (op == 4'h5) || (op == 4'h6);
        if (op == 4'h6) begin
            v.byl = 1'b1;
            v.exs = md;
        end
        push_v(v);
    endtask

    // Pops one expected vector per cycle; ends at posedge+1 of the next state.
    task automatic drain(input int n);
        exp_t e, a, ew, aw;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s cyc%0d: scoreboard empty", cur, i);
            end else begin
                e = q.pop_front();
                a = actual();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s cyc%0d: got %h want %h", cur, i, a, e);
                end
                ew = e;
                ew.cnt = {13'b0, e.cnt[2:0]};
                aw = actual_w();
                checks++;
                if (aw !== ew) begin
                    errors++;
                    $display("FAIL %s narrow cyc%0d: got %h want %h",
                             cur, i, aw, ew);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [3:0] op, input logic md,
                       input logic z, input logic n, input string name);
        cur = name;
        opcode = op;
        mode = md;
        zero = z;
        negative = n;
        push_instr(op, md, z, n);
        drain(q.size());
    endtask

    task automatic test_reset();
        exp_t a;
        cur = "reset";
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = actual();
            checks++;
            if (a !== exp_t'(0)) begin
                errors++;
                $display("FAIL reset cyc%0d: got %h want 0", i, a);
            end
            @(posedge clk);
        end
        #1;
        reset = 1'b0;
        model_cnt = '0;
    endtask

    task automatic test_alu();
        run(4'h1, 1'b0, 1'b0, 1'b0, "add");
        checks++;
        if (instr_count !== 16'd1) begin
            errors++;
            $display("FAIL add_count: got %0d want 1", instr_count);
        end
        run(4'h0, 1'b0, 1'b0, 1'b0, "and");
        run(4'h2, 1'b0, 1'b0, 1'b0, "sub");
        run(4'h3, 1'b0, 1'b0, 1'b0, "addi");
        run(4'h4, 1'b0, 1'b0, 1'b0, "andi");
    endtask

    task automatic test_load();
        run(4'h6, 1'b1, 1'b0, 1'b0, "lbs");
        run(4'h6, 1'b0, 1'b0, 1'b0, "lbu");
        run(4'h5, 1'b1, 1'b0, 1'b0, "lw");
    endtask

    task automatic test_branch();
        for (int op = 8; op <= 11; op++) begin
            for (int f = 0; f < 4; f++) begin
                run(4'(op), 1'b0, f[1], f[0], $sformatf("br%0h_z%0d_n%0d",
                    op, f[1], f[0]));
            end
        end
    endtask

    task automatic test_back_to_back();
        run(4'hD, 1'b0, 1'b0, 1'b0, "call");
        run(4'hE, 1'b0, 1'b0, 1'b0, "ret");
        run(4'hC, 1'b0, 1'b0, 1'b0, "jmp");
    endtask

    task automatic test_store();
        run(4'hF, 1'b0, 1'b0, 1'b0, "sv");
        run(4'h7, 1'b0, 1'b0, 1'b0, "sw");
    endtask

    task automatic test_reset_mid();
        exp_t v;
        cur = "rst_mid";
        opcode = 4'h5;
        push_instr(4'h5, 1'b0, 1'b0, 1'b0);
        drain(3);
        reset = 1'b1;
        q.delete();
        v = '0;
        v.st = 3'd3;
        model_cnt = '0;
        q.push_back(v);
        q[0].cnt = instr_count;
        drain(1);
        checks++;
        if (state !== 3'd0 || instr_count !== 16'd0 ||
            dmem_read !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: state=%0d cnt=%0d dr=%b rw=%b want 0 0 0 0",
                     state, instr_count, dmem_read, reg_write);
        end
        reset = 1'b0;
        run(4'h1, 1'b0, 1'b0, 1'b0, "add_after_rst");
        checks++;
        if (instr_count !== 16'd1) begin
            errors++;
            $display("FAIL rst_mid_count: got %0d want 1", instr_count);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_cnt = '0;
        for (int i = 0; i < 7; i++) run(4'hC, 1'b0, 1'b0, 1'b0, "wrap_jmp");
        checks++;
        if (w_instr_count !== 3'd7) begin
            errors++;
            $display("FAIL wrap_full: got %0d want 7", w_instr_count);
        end
        run(4'hC, 1'b0, 1'b0, 1'b0, "wrap_last");
        checks++;
        if (w_instr_count !== 3'd0 || instr_count !== 16'd8) begin
            errors++;
            $display("FAIL wrap_zero: got %0d/%0d want 0/8",
                     w_instr_count, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_back_to_back();
        test_store();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
